conv_event_scatter: RTL

Convolution-stage event expander directly downstream of the input event FIFO.
- Pops one spike event (x, y) at a time through the FIFO consumer handshake.
- Expands each event into the KERNEL_SIZE×KERNEL_SIZE set of affected output-neuron coordinates, each paired with its kernel tap index.
- Streams them over valid/ready to the membrane-update stage, clipping taps that fall outside the feature map.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/fifo_if.sv | 12 +
 rtl/kernel_tap_counter.sv | 36 +++
 rtl/conv_event_scatter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution event scatter: FSM states, coordinate and
// FIFO event packing.
package conv_pkg;

  localparam int unsigned CONV_COORD_WIDTH = 8;

  typedef logic [CONV_COORD_WIDTH-1:0] coord_t;

  // FIFO word layout: x in the low half, y in the high half
  typedef struct packed {
    coord_t y;
    coord_t x;
  } event_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_if.sv
// Event FIFO read-side bundle; the FIFO has a registered read (1-cycle latency).
interface fifo_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] read_data;
  logic                  empty;
  logic                  almost_empty;
  logic                  read_en;

  modport consumer (input read_data, input empty, input almost_empty, output read_en);
  modport producer (output read_data, output empty, output almost_empty, input read_en);
endinterface

// File: rtl/kernel_tap_counter.sv
// Kernel tap walker: kx inner, ky outer; done flags the final tap (K-1, K-1).
module kernel_tap_counter #(
  parameter int unsigned KERNEL_SIZE = 3,
  localparam int unsigned KW = $clog2(KERNEL_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  output logic [KW-1:0] kx,
  output logic [KW-1:0] ky,
  output logic          done
);

  localparam logic [KW-1:0] KMAX = KW'(KERNEL_SIZE - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0;
      ky <= '0;
    end else if (start) begin
      kx <= '0;
      ky <= '0;
    end else if (step) begin
      if (kx == KMAX) begin
        kx <= '0;
        ky <= (ky == KMAX) ? '0 : ky + KW'(1);
      end else begin
        kx <= kx + KW'(1);
      end
    end
  end

  assign done = (kx == KMAX) && (ky == KMAX);

endmodule

// File: rtl/conv_event_scatter.sv
// Pops spike events from the input FIFO and streams the clipped set of
// affected output-neuron coordinates with their kernel tap index.
module conv_event_scatter
  import conv_pkg::*;
#(
  parameter int unsigned COORD_WIDTH = CONV_COORD_WIDTH,
  parameter int unsigned IMG_WIDTH   = 32,
  parameter int unsigned IMG_HEIGHT  = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  localparam int unsigned KW = $clog2(KERNEL_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_if.consumer               fifo,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_WIDTH-1:0] out_x,
  output logic [COORD_WIDTH-1:0] out_y,
  output logic [KW-1:0]          out_kx,
  output logic [KW-1:0]          out_ky,
  output logic                   out_last,
  output logic                   event_dropped,
  output logic                   busy
);

  localparam int unsigned OFFSET = KERNEL_SIZE / 2;
  localparam int unsigned SW     = COORD_WIDTH + 2;
  localparam int unsigned XW     = COORD_WIDTH + 1;

  state_e                  state_q, state_d;
  logic [COORD_WIDTH-1:0]  ev_x_q, ev_y_q;
  logic [COORD_WIDTH-1:0]  rd_x, rd_y;
  logic [KW-1:0]           last_kx_q, last_ky_q, last_kx_d, last_ky_d;
  logic [KW-1:0]           kx, ky;
  logic [XW-1:0]           rd_xo, rd_yo;
  logic signed [SW-1:0]    ox, oy;
  logic                    done, start, step, in_range, tap_in, read_en_c;
  logic                    unused_almost_empty;

  assign rd_x = fifo.read_data[COORD_WIDTH-1:0];
  assign rd_y = fifo.read_data[2*COORD_WIDTH-1:COORD_WIDTH];
  assign unused_almost_empty = fifo.almost_empty;
  assign fifo.read_en = read_en_c;

  assign in_range = ({1'b0, rd_x} < XW'(IMG_WIDTH)) && ({1'b0, rd_y} < XW'(IMG_HEIGHT));

  // In-bounds kx/ky ranges are contiguous, so the last in-bounds tap is the
  // largest kx/ky still giving a non-negative coordinate.
  assign rd_xo     = {1'b0, rd_x} + XW'(OFFSET);
  assign rd_yo     = {1'b0, rd_y} + XW'(OFFSET);
  assign last_kx_d = (rd_xo >= XW'(KERNEL_SIZE - 1)) ? KW'(KERNEL_SIZE - 1) : rd_xo[KW-1:0];
  assign last_ky_d = (rd_yo >= XW'(KERNEL_SIZE - 1)) ? KW'(KERNEL_SIZE - 1) : rd_yo[KW-1:0];

  assign ox = $signed({2'b00, ev_x_q}) + $signed(SW'(OFFSET)) - $signed(SW'(kx));
  assign oy = $signed({2'b00, ev_y_q}) + $signed(SW'(OFFSET)) - $signed(SW'(ky));

  assign tap_in = !ox[SW-1] && (ox < $signed(SW'(IMG_WIDTH))) &&
                  !oy[SW-1] && (oy < $signed(SW'(IMG_HEIGHT)));

  kernel_tap_counter #(
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_taps (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .step  (step),
    .kx    (kx),
    .ky    (ky),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Event capture during the FIFO read-latency cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_x_q    <= '0;
      ev_y_q    <= '0;
      last_kx_q <= '0;
      last_ky_q <= '0;
    end else if (state_q == ST_WAIT) begin
      ev_x_q    <= rd_x;
      ev_y_q    <= rd_y;
      last_kx_q <= last_kx_d;
      last_ky_q <= last_ky_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    read_en_c     = 1'b0;
    start         = 1'b0;
    step          = 1'b0;
    event_dropped = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        read_en_c = !fifo.empty;
        if (!fifo.empty) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (in_range) begin
          start   = 1'b1;
          state_d = ST_EMIT;
        end else begin
          event_dropped = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_EMIT: begin
        out_valid = tap_in;
        out_last  = tap_in && (kx == last_kx_q) && (ky == last_ky_q);
        step      = !tap_in || out_ready;
        if (step && done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_x  = out_valid ? ox[COORD_WIDTH-1:0] : '0;
  assign out_y  = out_valid ? oy[COORD_WIDTH-1:0] : '0;
  assign out_kx = out_valid ? kx : '0;
  assign out_ky = out_valid ? ky : '0;
  assign busy   = (state_q != ST_IDLE);

endmodule
